// File: rtl/atm_keypad_frontend_if.sv
// Signal bundle between the raw keypad and the ATM keypad front-end.
// master: keypad/stimulus side; slave: the front-end itself.
interface atm_keypad_frontend_if;
  logic        tecla_valida;
  logic [3:0]  tecla;
  logic        modo_monto;
  logic [3:0]  digito;
  logic        add_digit;
  logic [31:0] monto;
  logic        monto_stb;
  logic        error_monto;

  modport master (
    output tecla_valida, tecla, modo_monto,
    input  digito, add_digit, monto, monto_stb, error_monto
  );

  modport slave (
    input  tecla_valida, tecla, modo_monto,
    output digito, add_digit, monto, monto_stb, error_monto
  );
endinterface

// File: rtl/atm_keypad_frontend.sv
// Keypad front-end: one acceptance per press, PIN digit forwarding or decimal amount accumulation.
// Optional debounce stage compiled in with `define KEYPAD_DEBOUNCE_EN.
module atm_keypad_frontend #(
  parameter int MAX_DIGITOS = 9,
  parameter int DEB_CICLOS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  atm_keypad_frontend_if.slave kp
);
  localparam int            CW      = $clog2(MAX_DIGITOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITOS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1
`ifdef KEYPAD_DEBOUNCE_EN
    , ST_DEB = 2'd2
`endif
  } state_t;

  state_t        state_r;
  logic          modo_prev_r;
  logic [31:0]   acc_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    digito_r;
  logic          add_digit_r;
  logic [31:0]   monto_r;
  logic          monto_stb_r;
  logic          error_monto_r;

  logic          accept_s;
  logic          mode_chg_s;
  logic          is_digit_s;
  logic [31:0]   acc_eff_s;
  logic [CW-1:0] cnt_eff_s;
  logic [35:0]   nx_s;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int            DW      = $clog2(DEB_CICLOS + 1);
  localparam logic [DW-1:0] DEB_LIM = DW'(DEB_CICLOS);
  logic [DW-1:0] deb_cnt_r;
  logic [3:0]    deb_code_r;
`endif

  // Acceptance strobe and mode-change-adjusted accumulator view
  always_comb begin
    accept_s   = 1'b0;
    mode_chg_s = (kp.modo_monto != modo_prev_r);
    is_digit_s = (kp.tecla <= 4'd9);
    if (mode_chg_s) begin
      acc_eff_s = 32'd0;
      cnt_eff_s = {CW{1'b0}};
    end else begin
      acc_eff_s = acc_r;
      cnt_eff_s = cnt_r;
    end
    // 36 bits is enough for (2^32-1)*10 + 9
    nx_s = ({4'd0, acc_eff_s} * 36'd10) + {32'd0, kp.tecla};
    case (state_r)
      ST_IDLE: begin
`ifdef KEYPAD_DEBOUNCE_EN
        accept_s = kp.tecla_valida && (DEB_CICLOS <= 1);
`else
        accept_s = kp.tecla_valida;
`endif
      end
`ifdef KEYPAD_DEBOUNCE_EN
      ST_DEB: begin
        accept_s = kp.tecla_valida && (kp.tecla == deb_code_r) &&
                   ((deb_cnt_r + DW'(1)) == DEB_LIM);
      end
`endif
      ST_HOLD: accept_s = 1'b0;
      default: accept_s = 1'b0;
    endcase
  end

  // Press FSM, accumulator and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      modo_prev_r   <= 1'b0;
      acc_r         <= 32'd0;
      cnt_r         <= {CW{1'b0}};
      digito_r      <= 4'd0;
      add_digit_r   <= 1'b0;
      monto_r       <= 32'd0;
      monto_stb_r   <= 1'b0;
      error_monto_r <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
      deb_cnt_r     <= {DW{1'b0}};
      deb_code_r    <= 4'd0;
`endif
    end else begin
      add_digit_r   <= 1'b0;
      monto_stb_r   <= 1'b0;
      error_monto_r <= 1'b0;
      modo_prev_r   <= kp.modo_monto;
      acc_r         <= acc_eff_s;
      cnt_r         <= cnt_eff_s;

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_HOLD;
          end
`ifdef KEYPAD_DEBOUNCE_EN
          else if (kp.tecla_valida) begin
            state_r    <= ST_DEB;
            deb_cnt_r  <= DW'(1);
            deb_code_r <= kp.tecla;
          end
`endif
        end
`ifdef KEYPAD_DEBOUNCE_EN
        ST_DEB: begin
          if (accept_s) begin
            state_r   <= ST_HOLD;
            deb_cnt_r <= {DW{1'b0}};
          end else if (kp.tecla_valida && (kp.tecla == deb_code_r)) begin
            deb_cnt_r <= deb_cnt_r + DW'(1);
          end else begin
            state_r   <= ST_IDLE;
            deb_cnt_r <= {DW{1'b0}};
          end
        end
`endif
        ST_HOLD: begin
          if (!kp.tecla_valida) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase

      if (accept_s) begin
        if (kp.modo_monto) begin
          if (is_digit_s) begin
            if ((nx_s > 36'h0_FFFF_FFFF) || (cnt_eff_s == CNT_MAX)) begin
              error_monto_r <= 1'b1;
              acc_r         <= 32'd0;
              cnt_r         <= {CW{1'b0}};
            end else begin
              acc_r <= nx_s[31:0];
              cnt_r <= cnt_eff_s + CW'(1);
            end
          end else if (kp.tecla == 4'hA) begin
            if (cnt_eff_s != {CW{1'b0}}) begin
              monto_r     <= acc_eff_s;
              monto_stb_r <= 1'b1;
              acc_r       <= 32'd0;
              cnt_r       <= {CW{1'b0}};
            end
          end else if (kp.tecla == 4'hB) begin
            acc_r <= 32'd0;
            cnt_r <= {CW{1'b0}};
          end
        end else if (is_digit_s) begin
          digito_r    <= kp.tecla;
          add_digit_r <= 1'b1;
        end
      end
    end
  end

  assign kp.digito      = digito_r;
  assign kp.add_digit   = add_digit_r;
  assign kp.monto       = monto_r;
  assign kp.monto_stb   = monto_stb_r;
  assign kp.error_monto = error_monto_r;
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Scoreboard bench for atm_keypad_frontend: two instances (MAX_DIGITOS 9 and 10) share stimulus,
// expected strobes are queued per instance and popped by a negedge monitor.
module tb_atm_keypad_frontend;
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  localparam logic [1:0] EV_DIG   = 2'd0;
  localparam logic [1:0] EV_MONTO = 2'd1;
  localparam logic [1:0] EV_ERR   = 2'd2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  atm_keypad_frontend_if kp0();
  atm_keypad_frontend_if kp1();

  atm_keypad_frontend #(.MAX_DIGITOS(9), .DEB_CICLOS(4)) dut0 (
    .clk(clk), .rst(rst), .kp(kp0.slave)
  );
  atm_keypad_frontend #(.MAX_DIGITOS(10), .DEB_CICLOS(4)) dut1 (
    .clk(clk), .rst(rst), .kp(kp1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic ad, input logic sb, input logic er,
                     input logic [3:0] dg, input logic [31:0] mt);
    ev_t        e;
    logic [1:0] k;
    if (ad || sb || er) begin
      k = ad ? EV_DIG : (sb ? EV_MONTO : EV_ERR);
      check($sformatf("dut%0d_strobe_excl", id), 32'(ad) + 32'(sb) + 32'(er), 32'd1);
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected: got strobe kind %0d expected none", id, k);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d_kind", id), 32'(k), 32'(e.kind));
        if (e.kind == EV_DIG) check($sformatf("dut%0d_digito", id), 32'(dg), e.val);
        else if (e.kind == EV_MONTO) check($sformatf("dut%0d_monto", id), mt, e.val);
      end
    end
  endtask

  // Monitor: pop and compare whenever a strobe is presented
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, kp0.add_digit, kp0.monto_stb, kp0.error_monto, kp0.digito, kp0.monto);
      mon(1, kp1.add_digit, kp1.monto_stb, kp1.error_monto, kp1.digito, kp1.monto);
    end
  end

  task automatic push_both(input logic [1:0] k, input logic [31:0] v);
    q0.push_back(ev_t'{kind: k, val: v});
    q1.push_back(ev_t'{kind: k, val: v});
  endtask

  task automatic drive(input logic vld, input logic [3:0] key);
    kp0.tecla_valida = vld;
    kp1.tecla_valida = vld;
    kp0.tecla        = key;
    kp1.tecla        = key;
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk);
    kp0.modo_monto = m;
    kp1.modo_monto = m;
  endtask

  task automatic press(input logic [3:0] key, input int hold);
    @(negedge clk);
    drive(1'b1, key);
    repeat (hold) @(negedge clk);
    drive(1'b0, key);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digito0"}, 32'(kp0.digito), 32'd0);
    check({tag, "_add_digit0"}, 32'(kp0.add_digit), 32'd0);
    check({tag, "_monto0"}, kp0.monto, 32'd0);
    check({tag, "_monto_stb0"}, 32'(kp0.monto_stb), 32'd0);
    check({tag, "_error0"}, 32'(kp0.error_monto), 32'd0);
    check({tag, "_digito1"}, 32'(kp1.digito), 32'd0);
    check({tag, "_monto1"}, kp1.monto, 32'd0);
  endtask

  int pin_keys[4] = '{4, 7, 5, 6};
  int big_keys[9] = '{4, 2, 9, 4, 9, 6, 7, 2, 9};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 4'd0);
    kp0.modo_monto = 1'b0;
    kp1.modo_monto = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // PIN entry, then non-digit keys must be ignored
    foreach (pin_keys[i]) begin
      push_both(EV_DIG, 32'(pin_keys[i]));
      press(4'(pin_keys[i]), 6);
    end
    press(4'hA, 6);
    press(4'hB, 6);
    press(4'hC, 6);
    check("pin_digito_hold", 32'(kp0.digito), 32'd6);

    // Amount 10000, then ENTER with no digits
    set_mode(1'b1);
    press(4'd1, 6);
    repeat (4) press(4'd0, 6);
    push_both(EV_MONTO, 32'd10000);
    press(4'hA, 6);
    press(4'hA, 6);
    check("monto_hold0", kp0.monto, 32'd10000);
    check("monto_hold1", kp1.monto, 32'd10000);

    // 4294967295: digit-count limit on dut0, exact max value on dut1
    foreach (big_keys[i]) press(4'(big_keys[i]), 6);
    q0.push_back(ev_t'{kind: EV_ERR, val: 32'd0});
    press(4'd5, 6);
    q1.push_back(ev_t'{kind: EV_MONTO, val: 32'hFFFF_FFFF});
    press(4'hA, 6);

    // 4294967296: overflow on both, following ENTER gives nothing
    foreach (big_keys[i]) press(4'(big_keys[i]), 6);
    push_both(EV_ERR, 32'd0);
    press(4'd6, 6);
    press(4'hA, 6);
    check("monto_after_err0", kp0.monto, 32'd10000);
    check("monto_after_err1", kp1.monto, 32'hFFFF_FFFF);

    // CLEAR discards partial entry
    press(4'd5, 6);
    press(4'd5, 6);
    press(4'hB, 6);
    press(4'd7, 6);
    push_both(EV_MONTO, 32'd7);
    press(4'hA, 6);

    // Mode toggle discards partial entry
    press(4'd3, 6);
    press(4'd3, 6);
    set_mode(1'b0);
    repeat (2) @(negedge clk);
    set_mode(1'b1);
    repeat (2) @(negedge clk);
    press(4'd8, 6);
    push_both(EV_MONTO, 32'd8);
    press(4'hA, 6);

`ifdef KEYPAD_DEBOUNCE_EN
    // Short glitch and mid-press code change
    set_mode(1'b0);
    press(4'd1, 2);
    @(negedge clk);
    drive(1'b1, 4'd3);
    repeat (2) @(negedge clk);
    push_both(EV_DIG, 32'd5);
    drive(1'b1, 4'd5);
    repeat (8) @(negedge clk);
    drive(1'b0, 4'd5);
    repeat (2) @(negedge clk);
`endif

    // Reset while a key is held: outputs clear, key accepted once afterwards
    set_mode(1'b0);
    push_both(EV_DIG, 32'd9);
    @(negedge clk);
    drive(1'b1, 4'd9);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    push_both(EV_DIG, 32'd9);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    drive(1'b0, 4'd9);
    repeat (3) @(negedge clk);
    check("post_rst_digito", 32'(kp1.digito), 32'd9);
    check("post_rst_monto", kp0.monto, 32'd0);

    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
